// File: rtl/ahb_master_mux_if.sv
// Purpose : bundle of upstream-master and shared-bus signals for ahb_master_mux.
// Ports   : slave modport = mux side (consumes per-master fields, drives bus);
//           master modport = upstream/environment side (the mirror image).
interface ahb_master_mux_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // arbiter / slave-mux inputs
  logic [1:0]          Hmaster;
  logic                Hready;
  // per-master request fields, master i in slice i
  logic [4*ADDR_W-1:0] Haddr_m;
  logic [7:0]          Htrans_m;
  logic [3:0]          Hwrite_m;
  logic [11:0]         Hsize_m;
  logic [11:0]         Hburst_m;
  logic [4*DATA_W-1:0] Hwdata_m;
  // shared bus outputs
  logic [ADDR_W-1:0]   Haddr;
  logic [1:0]          Htrans;
  logic                Hwrite;
  logic [2:0]          Hsize;
  logic [2:0]          Hburst;
  logic [DATA_W-1:0]   Hwdata;
  logic [1:0]          Hmaster_data;
  logic                Hburst_last;
  logic                Hseq_err;

  modport slave (
    input  Hmaster, Hready, Haddr_m, Htrans_m, Hwrite_m, Hsize_m, Hburst_m, Hwdata_m,
    output Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata, Hmaster_data, Hburst_last, Hseq_err
  );

  modport master (
    output Hmaster, Hready, Haddr_m, Htrans_m, Hwrite_m, Hsize_m, Hburst_m, Hwdata_m,
    input  Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata, Hmaster_data, Hburst_last, Hseq_err
  );
endinterface

// File: rtl/ahb_master_mux.sv
// Purpose : 4-master AHB address/write-data mux with burst beat tracking.
// Latency : address phase combinational; write data follows one accepted beat later.
// Backpressure: Hready=0 freezes data-phase owner and all beat state.
// Ports   : Hclk, Hreset (sync, active-high); bus = ahb_master_mux_if.slave
//           (Hmaster/Hready/per-master fields in; Haddr..Hburst, Hwdata,
//           Hmaster_data, Hburst_last, Hseq_err out).
// Option  : define AHB_MUX_PROT_CHECK_EN to build the sticky Hseq_err checker;
//           otherwise Hseq_err is tied low.
module ahb_master_mux #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic            Hclk,
  input  logic            Hreset,
  ahb_master_mux_if.slave bus
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] BU_SINGLE = 3'd0;
  localparam logic [2:0] BU_INCR   = 3'd1;

  // per-master fields unpacked for indexed selection
  logic [ADDR_W-1:0] addr_arr  [4];
  logic [1:0]        trans_arr [4];
  logic              write_arr [4];
  logic [2:0]        size_arr  [4];
  logic [2:0]        burst_arr [4];
  logic [DATA_W-1:0] wdata_arr [4];

  genvar g;
  for (g = 0; g < 4; g++) begin : g_unpack
    assign addr_arr[g]  = bus.Haddr_m[g*ADDR_W +: ADDR_W];
    assign trans_arr[g] = bus.Htrans_m[g*2 +: 2];
    assign write_arr[g] = bus.Hwrite_m[g];
    assign size_arr[g]  = bus.Hsize_m[g*3 +: 3];
    assign burst_arr[g] = bus.Hburst_m[g*3 +: 3];
    assign wdata_arr[g] = bus.Hwdata_m[g*DATA_W +: DATA_W];
  end

  logic [1:0] master_data;
  logic [3:0] beat_cnt;   // beats remaining after the last accepted beat
  logic       incr_act;   // undefined-length INCR burst in progress
  logic [1:0] htrans_bus;
  logic [2:0] hburst_bus;

  // Bus HTRANS is forced IDLE in reset so no beat is ever seen as accepted.
  assign htrans_bus = Hreset ? TR_IDLE : trans_arr[bus.Hmaster];
  assign hburst_bus = burst_arr[bus.Hmaster];

  assign bus.Haddr        = addr_arr[bus.Hmaster];
  assign bus.Htrans       = htrans_bus;
  assign bus.Hwrite       = write_arr[bus.Hmaster];
  assign bus.Hsize        = size_arr[bus.Hmaster];
  assign bus.Hburst       = hburst_bus;
  assign bus.Hwdata       = wdata_arr[master_data];
  assign bus.Hmaster_data = master_data;

  // Beats remaining after a NONSEQ; INCR and SINGLE both leave nothing to count.
  function automatic logic [3:0] burst_len_m1(input logic [2:0] b);
    logic [3:0] n;
    n = 4'd0;
    case (b)
      3'd2, 3'd3: n = 4'd3;
      3'd4, 3'd5: n = 4'd7;
      3'd6, 3'd7: n = 4'd15;
      default:    n = 4'd0;
    endcase
    return n;
  endfunction

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      master_data <= 2'd0;
      beat_cnt    <= 4'd0;
      incr_act    <= 1'b0;
    end else if (bus.Hready) begin
      master_data <= bus.Hmaster;
      case (htrans_bus)
        TR_NONSEQ: begin
          // also covers arbiter early-termination: a new NONSEQ just reloads
          beat_cnt <= burst_len_m1(hburst_bus);
          incr_act <= (hburst_bus == BU_INCR);
        end
        TR_SEQ: begin
          if (beat_cnt != 4'd0) beat_cnt <= beat_cnt - 4'd1;
        end
        TR_IDLE: begin
          beat_cnt <= 4'd0;
          incr_act <= 1'b0;
        end
        default: ; // BUSY leaves the burst untouched
      endcase
    end
  end

  // Last beat is known from the current presentation plus the prior count.
  assign bus.Hburst_last = ((htrans_bus == TR_NONSEQ) && (hburst_bus == BU_SINGLE)) ||
                           ((htrans_bus == TR_SEQ) && !incr_act && (beat_cnt == 4'd1));

`ifdef AHB_MUX_PROT_CHECK_EN
  logic seq_err;

  // SEQ/BUSY with no burst open is a master protocol violation.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      seq_err <= 1'b0;
    end else if (bus.Hready && ((htrans_bus == TR_SEQ) || (htrans_bus == TR_BUSY)) &&
                 (beat_cnt == 4'd0) && !incr_act) begin
      seq_err <= 1'b1;
    end
  end

  assign bus.Hseq_err = seq_err;
`else
  assign bus.Hseq_err = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_master_mux.sv
// Purpose : self-checking bench for ahb_master_mux (vector table + owner scoreboard).
// Latency : checks combinational outputs 1 time unit after each falling edge.
// Backpressure: vectors carry Hready=0 rows to exercise wait states.
module tb_ahb_master_mux;

`ifdef AHB_MUX_PROT_CHECK_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  localparam logic [1:0] I = 2'b00, B = 2'b01, N = 2'b10, S = 2'b11;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, INCR8 = 3'd5;

  logic Hclk = 1'b0;
  logic Hreset;
  always #5 Hclk = ~Hclk;

  ahb_master_mux_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_master_mux #(.ADDR_W(32), .DATA_W(32)) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus)
  );

  typedef struct packed {
    logic       rst;
    logic [1:0] mst;
    logic       rdy;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       last;
    logic       err;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] own_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic v(input logic rst, input logic [1:0] mst, input logic rdy,
                   input logic [1:0] trans, input logic [2:0] burst,
                   input logic last, input logic err);
    vec_t r;
    r = '{rst: rst, mst: mst, rdy: rdy, trans: trans, burst: burst, last: last, err: err};
    vecs.push_back(r);
  endtask

  // Selected master gets the vector fields; others get inverted ones so a
  // wrong select shows up on the bus.
  task automatic drive(input logic rst, input logic [1:0] mst, input logic rdy,
                       input logic [1:0] trans, input logic [2:0] burst, input int k);
    Hreset      = rst;
    bus.Hmaster = mst;
    bus.Hready  = rdy;
    for (int i = 0; i < 4; i++) begin
      bus.Htrans_m[i*2 +: 2]  = (i == int'(mst)) ? trans : ~trans;
      bus.Hburst_m[i*3 +: 3]  = (i == int'(mst)) ? burst : ~burst;
      bus.Haddr_m[i*32 +: 32] = {8'(i), 8'h00, 16'(k)};
      bus.Hwdata_m[i*32 +: 32] = {8'(i), 16'(k), 8'hA0};
      bus.Hwrite_m[i]         = i[0] ^ k[0];
      bus.Hsize_m[i*3 +: 3]   = 3'(i) + 3'(k);
    end
  endtask

  initial begin
    // ---- reset: Htrans forced IDLE, reset beats Hready=1 with Hmaster=3 ----
    drive(1'b1, 2'd3, 1'b1, N, SINGLE, 0);
    for (int r = 0; r < 3; r++) begin
      @(negedge Hclk);
      drive(1'b1, 2'd3, 1'b1, N, SINGLE, r);
      #1;
      chk("rst_htrans", 32'(bus.Htrans), 32'(I));
      chk("rst_last", 32'(bus.Hburst_last), 32'd0);
      chk("rst_mdata", 32'(bus.Hmaster_data), 32'd0);
      chk("rst_err", 32'(bus.Hseq_err), 32'd0);
    end
    own_q.push_back(2'd0);

    // ---- vector table ----
    v(0,0,1,I,SINGLE,0,0);
    // INCR4 from master 2
    v(0,2,1,N,INCR4,0,0); v(0,2,1,S,INCR4,0,0); v(0,2,1,S,INCR4,0,0);
    v(0,2,1,S,INCR4,1,0); v(0,2,1,I,INCR4,0,0);
    // same INCR4 with two wait states on beat 2
    v(0,2,1,N,INCR4,0,0); v(0,2,0,S,INCR4,0,0); v(0,2,0,S,INCR4,0,0);
    v(0,2,1,S,INCR4,0,0); v(0,2,1,S,INCR4,0,0); v(0,2,1,S,INCR4,1,0);
    v(0,2,1,I,INCR4,0,0);
    // handover: master 1 SINGLE then master 3 INCR8
    v(0,1,1,N,SINGLE,1,0); v(0,3,1,N,INCR8,0,0);
    for (int i = 0; i < 6; i++) v(0,3,1,S,INCR8,0,0);
    v(0,3,1,S,INCR8,1,0); v(0,3,1,I,INCR8,0,0);
    // undefined-length INCR, 6 SEQ beats
    v(0,0,1,N,INCR,0,0);
    for (int i = 0; i < 6; i++) v(0,0,1,S,INCR,0,0);
    v(0,0,1,I,INCR,0,0);
    // BUSY inside a fixed burst
    v(0,1,1,N,INCR4,0,0); v(0,1,1,B,INCR4,0,0); v(0,1,1,S,INCR4,0,0);
    v(0,1,1,S,INCR4,0,0); v(0,1,1,S,INCR4,1,0); v(0,1,1,I,INCR4,0,0);
    // early termination: INCR8 cut by a new NONSEQ INCR4
    v(0,2,1,N,INCR8,0,0); v(0,2,1,S,INCR8,0,0); v(0,1,1,N,INCR4,0,0);
    v(0,1,1,S,INCR4,0,0); v(0,1,1,S,INCR4,0,0); v(0,1,1,S,INCR4,1,0);
    v(0,1,1,I,INCR4,0,0);
    // reset mid-burst with Hready=0: state cleared, stray SEQs never "last"
    v(0,3,1,N,INCR4,0,0); v(0,3,1,S,INCR4,0,0); v(1,3,0,S,INCR4,0,0);
    v(0,3,1,S,INCR4,0,0); v(0,3,1,S,INCR4,0,1);
    v(1,0,1,I,SINGLE,0,1); v(0,0,1,I,SINGLE,0,0);
    // SEQ after IDLE: sticky error
    v(0,0,1,S,SINGLE,0,0); v(0,0,1,I,SINGLE,0,1); v(0,0,0,I,SINGLE,0,1);
    v(0,0,1,N,SINGLE,1,1); v(0,0,1,I,SINGLE,0,1);

    for (int k = 0; k < vecs.size(); k++) begin
      vec_t       r;
      logic [1:0] own;
      int         kk;
      r  = vecs[k];
      kk = k + 16;
      @(negedge Hclk);
      drive(r.rst, r.mst, r.rdy, r.trans, r.burst, kk);
      #1;
      own = own_q.pop_front();
      chk("haddr", bus.Haddr, {8'(r.mst), 8'h00, 16'(kk)});
      chk("htrans", 32'(bus.Htrans), r.rst ? 32'(I) : 32'(r.trans));
      chk("ctrl", 32'({bus.Hwrite, bus.Hsize, bus.Hburst}),
          32'({r.mst[0] ^ kk[0], 3'(r.mst) + 3'(kk), r.burst}));
      chk("last", 32'(bus.Hburst_last), 32'(r.last));
      chk("mdata", 32'(bus.Hmaster_data), 32'(own));
      chk("hwdata", bus.Hwdata, {8'(own), 16'(kk), 8'hA0});
      chk("seq_err", 32'(bus.Hseq_err), PROT ? 32'(r.err) : 32'd0);
      own_q.push_back(r.rst ? 2'd0 : (r.rdy ? r.mst : own));
    end

    // ---- reset clears sticky error and wins over Hready=1 ----
    @(negedge Hclk);
    drive(1'b0, 2'd2, 1'b1, N, INCR4, 200);
    #1;
    chk("err_sticky", 32'(bus.Hseq_err), PROT ? 32'd1 : 32'd0);
    @(negedge Hclk);
    drive(1'b1, 2'd3, 1'b1, N, INCR4, 201);
    #1;
    chk("mdata_pre_rst", 32'(bus.Hmaster_data), 32'd2);
    chk("rst_htrans2", 32'(bus.Htrans), 32'(I));
    @(posedge Hclk);
    #1;
    chk("err_cleared", 32'(bus.Hseq_err), 32'd0);
    chk("rst_wins_mdata", 32'(bus.Hmaster_data), 32'd0);
    chk("rst_wins_hwdata", bus.Hwdata, {8'd0, 16'd201, 8'hA0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_master_mux.md
# ahb_master_mux

Bus-side master multiplexer that sits directly downstream of `ahb_arbiter` and consumes its `Hmaster` output. It routes the granted master's address/control onto the shared AHB bus in the address phase and that same master's write data one accepted transfer later. It also tracks burst beats on the shared bus, and feeds `Htrans`/`Hburst`/`Hburst_last` back to the arbiter for re-arbitration decisions. Four masters, fixed.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, write-data width

Ports:
- `Hclk`  in  1  bus clock; all state updates on rising edge
- `Hreset`  in  1  synchronous, active-high reset
- `Hmaster`  in  2  address-phase owner, from `ahb_arbiter`
- `Hready`  in  1  transfer-accepted / data-phase-complete, from slave mux
- `Haddr_m`  in  4*ADDR_W  per-master address; master i at `[i*ADDR_W +: ADDR_W]`
- `Htrans_m`  in  8  per-master HTRANS, 2 bits each
- `Hwrite_m`  in  4  per-master HWRITE
- `Hsize_m`  in  12  per-master HSIZE, 3 bits each
- `Hburst_m`  in  12  per-master HBURST, 3 bits each
- `Hwdata_m`  in  4*DATA_W  per-master write data
- `Haddr`  out  ADDR_W  bus address
- `Htrans`  out  2  bus HTRANS
- `Hwrite`  out  1  bus HWRITE
- `Hsize`  out  3  bus HSIZE
- `Hburst`  out  3  bus HBURST
- `Hwdata`  out  DATA_W  bus write data, selected by data-phase owner
- `Hmaster_data`  out  2  data-phase owner (registered)
- `Hburst_last`  out  1  current address-phase beat is the final beat of a fixed-length burst or SINGLE
- `Hseq_err`  out  1  sticky protocol-violation flag

## Operation
- Address phase (combinational): `Haddr`, `Htrans`, `Hwrite`, `Hsize`, `Hburst` = master `Hmaster` fields. While `Hreset`=1, `Htrans` is forced to IDLE (2'b00).
- Data phase: `Hmaster_data` <= `Hmaster` on every edge with `Hready`=1; it holds while `Hready`=0. `Hwdata` = master `Hmaster_data` data, combinational.
- An *accepted* beat is a rising edge where `Hready`=1 and `Reset`=0. Its type is the bus `Htrans`.
- Burst length L from `Hburst`: SINGLE=1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16, INCR=undefined.
- State:
  - `beat_cnt` (4 bits) = beats remaining after the last accepted beat.
  - `incr_act` (1 bit) = undefined-length INCR burst in progress.
- Updates on an accepted beat:
  - NONSEQ: `beat_cnt` <= L-1 for fixed bursts, else 0. `incr_act` <= (`Hburst`==INCR).
  - SEQ: `beat_cnt` <= `beat_cnt`-1, saturating at 0. `incr_act` holds.
  - IDLE: `beat_cnt` <= 0, `incr_act` <= 0.
  - BUSY: no change.
  - No accepted beat: all state holds.
- `Hburst_last` (combinational) is 1 when either:
  - `Htrans`==NONSEQ and `Hburst`==SINGLE, or
  - `Htrans`==SEQ, `incr_act`=0 and `beat_cnt`==1.
  - It is never asserted for INCR.
- `Hseq_err` sets on an accepted SEQ or BUSY when `beat_cnt`==0 and `incr_act`=0. It is sticky until reset.
- A master change with NONSEQ mid-burst (early termination by arbiter) simply reloads the counter. This is not an error.

## Timing
- Reset values: `Hmaster_data`=0, `beat_cnt`=0, `incr_act`=0, `Hseq_err`=0. Therefore `Hwdata` = master 0 data and `Htrans`=IDLE during reset.
- Address-phase outputs: zero-cycle latency from `Hmaster` and master inputs.
- `Hwdata` ownership: exactly one accepted beat behind address ownership. Wait states (`Hready`=0) extend both phases equally.
- `Hburst_last` reflects state from the previous edge plus current inputs. It is valid the same cycle the final beat is presented.
- `Hreset` asserted mid-burst: all state cleared on that edge, regardless of `Hready`. The next NONSEQ starts a fresh burst.
- Simultaneous `Hreset`=1 and `Hready`=1: reset wins.

## Configuration
- `AHB_MUX_PROT_CHECK_EN` defined: `Hseq_err` logic is present, as described above.
- Not defined: `Hseq_err` is tied to 0 and no check logic is synthesized. All other behaviour is identical.

## Test plan
- Reset 3 cycles, then release → `Htrans`=00 during reset, `Hmaster_data`=0, `Hseq_err`=0. After release, `Htrans` follows master 0.
- `Hmaster`=2, master 2 issues INCR4 (NONSEQ + 3 SEQ, `Hready`=1), `Hwdata_m[2]`=0xA0..0xA3 → `Hmaster_data`=2 from beat 2 onward. `Hburst_last`=1 only on the 4th address beat. `Hwdata` sequence 0xA0..0xA3 lags addresses by 1 cycle.
- Same INCR4 with `Hready`=0 for 2 cycles on beat 2 → `Hmaster_data` and `beat_cnt` hold. `Hburst_last` still fires on the 4th beat only.
- Handover: master 1 SINGLE, then `Hmaster`=3 NONSEQ INCR8 → `Hburst_last`=1 on the SINGLE. `Hmaster_data` changes 1→3 one accepted beat after the handover. `Hburst_last` then fires on beat 8.
- INCR burst of 6 SEQ beats → `Hburst_last` never asserted, `Hseq_err`=0.
- SEQ issued after IDLE (with `AHB_MUX_PROT_CHECK_EN`) → `Hseq_err`=1 from the next cycle, and it stays 1 until `Hreset`.
